// File: rtl/serial_audio_pkg.sv
// Shared types and constants for the serial audio sample path.
package serial_audio_pkg;

  localparam int DATA_W_DEF = 11;
  localparam int SLOT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } tx_state_t;

  function automatic int slot_cnt_w(input int slot_w);
    return (slot_w > 1) ? $clog2(slot_w) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; push/pop are ignored when full/empty respectively.
module sample_fifo #(
  parameter  int W     = 11,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic                    push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/serial_sample_tx.sv
// Serial sample transmitter: FIFO-fed, fixed SLOT_W-clock slots with WS select.
// Build option TX_MSB_FIRST_EN: shift samples MSB first instead of LSB first.
module serial_sample_tx
  import serial_audio_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int SLOT_W     = SLOT_W_DEF,
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              underrun_clr,
  output logic              data_out,
  output logic              WS,
  output logic              slot_start,
  output logic              underrun,
  output logic [LW-1:0]     fifo_level
);

  localparam int CW = slot_cnt_w(SLOT_W);

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d, head, first_word, ld_rest, sh_rest;
  logic              dout_q, dout_d, ws_q, ws_d, ss_q, ss_d, und_q, und_d;
  logic              full, empty, push, pop, start, last, to_idle, ld_bit, sh_bit;

  assign s_ready = !full;
  assign push    = s_valid && !full;
  assign pop     = start && !empty;

  sample_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (Clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (s_data),
    .rdata_o (head),
    .level_o (fifo_level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Right slot ending with tx_en low closes the frame; otherwise slots chain.
  assign last       = (state_q != IDLE) && (cnt_q == CW'(SLOT_W - 1));
  assign to_idle    = last && ws_q && !tx_en;
  assign start      = (state_q == IDLE) ? tx_en : (last && !to_idle);
  assign first_word = empty ? '0 : head;

`ifdef TX_MSB_FIRST_EN
  assign ld_bit  = first_word[DATA_W-1];
  assign ld_rest = first_word << 1;
  assign sh_bit  = sr_q[DATA_W-1];
  assign sh_rest = sr_q << 1;
`else
  assign ld_bit  = first_word[0];
  assign ld_rest = first_word >> 1;
  assign sh_bit  = sr_q[0];
  assign sh_rest = sr_q >> 1;
`endif

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)                                              state_d = SHIFT;
    else if (to_idle)                                       state_d = IDLE;
    else if (state_q != IDLE && cnt_q >= CW'(DATA_W - 1))   state_d = PAD;
  end

  always_comb begin
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    dout_d = dout_q;
    ws_d   = ws_q;
    ss_d   = 1'b0;
    und_d  = underrun_clr ? 1'b0 : und_q;
    if (start) begin
      cnt_d  = '0;
      ws_d   = (state_q == IDLE) ? 1'b0 : !ws_q;
      ss_d   = 1'b1;
      dout_d = ld_bit;
      sr_d   = ld_rest;
      if (empty) und_d = 1'b1;
    end else if (to_idle) begin
      cnt_d  = '0;
      ws_d   = 1'b0;
      dout_d = 1'b0;
      sr_d   = '0;
    end else if (state_q != IDLE) begin
      cnt_d  = cnt_q + CW'(1);
      dout_d = (state_d == SHIFT) ? sh_bit : 1'b0;
      sr_d   = sh_rest;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      dout_q <= 1'b0;
      ws_q   <= 1'b0;
      ss_q   <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      dout_q <= dout_d;
      ws_q   <= ws_d;
      ss_q   <= ss_d;
      und_q  <= und_d;
    end
  end

  assign data_out   = dout_q;
  assign WS         = ws_q;
  assign slot_start = ss_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_serial_sample_tx.sv
// Scoreboard bench: directed scenarios queue expected slots, a monitor checks each slot.
module tb_serial_sample_tx;

  localparam int DW = 11;
  localparam int SW = 16;
  localparam int FD = 4;

  logic          Clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_en = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          underrun_clr = 1'b0;
  logic          s_ready, data_out, WS, slot_start, underrun;
  logic [2:0]    fifo_level;

  typedef struct {
    logic          ws;
    logic [SW-1:0] bits;
  } slot_t;

  slot_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  localparam logic [DW-1:0] SA    = 11'b10010001110;
  localparam logic [DW-1:0] SB    = 11'b01101110001;
  localparam logic [DW-1:0] SONES = 11'h7FF;
  localparam logic [DW-1:0] SPAL  = 11'h401;
`ifdef TX_MSB_FIRST_EN
  localparam logic [SW-1:0] PA = 16'b00000_01110001001;
  localparam logic [SW-1:0] PB = 16'b00000_10001110110;
`else
  localparam logic [SW-1:0] PA = 16'b00000_10010001110;
  localparam logic [SW-1:0] PB = 16'b00000_01101110001;
`endif
  localparam logic [SW-1:0] PONES = 16'h07FF;
  localparam logic [SW-1:0] PPAL  = 16'h0401;

  serial_sample_tx #(.DATA_W(DW), .SLOT_W(SW), .FIFO_DEPTH(FD)) dut (
    .Clk          (Clk),
    .reset        (reset),
    .tx_en        (tx_en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .underrun_clr (underrun_clr),
    .data_out     (data_out),
    .WS           (WS),
    .slot_start   (slot_start),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tx_en = 1'b0;
    s_valid = 1'b0;
    underrun_clr = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic expect_slot(input logic ws, input logic [SW-1:0] bits);
    slot_t e;
    e.ws = ws;
    e.bits = bits;
    exp_q.push_back(e);
  endtask

  // Monitor: capture each slot from its slot_start pulse and compare with the queue head.
  initial begin
    slot_t         e;
    logic [SW-1:0] got;
    logic          ws0, ws_ok, ss_ok, aborted;
    forever begin
      @(negedge Clk);
      if (reset && slot_start) begin
        got = '0;
        got[0] = data_out;
        ws0 = WS;
        ws_ok = 1'b1;
        ss_ok = 1'b1;
        aborted = 1'b0;
        for (int k = 1; k < SW; k++) begin
          @(negedge Clk);
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
          got[k] = data_out;
          if (WS !== ws0) ws_ok = 1'b0;
          if (slot_start !== 1'b0) ss_ok = 1'b0;
        end
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_slot: got slot ws=%0b bits=%0h, expected no slot", ws0, got);
        end else begin
          e = exp_q.pop_front();
          if (!aborted) begin
            check("slot_ws", {31'd0, ws0}, {31'd0, e.ws});
            check("slot_bits", {16'd0, got}, {16'd0, e.bits});
            check("slot_ws_steady_and_single_pulse", {30'd0, ws_ok, ss_ok}, 32'd3);
          end
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] cs [5];
    cs[0] = SONES; cs[1] = SPAL; cs[2] = 11'h123; cs[3] = 11'h055; cs[4] = 11'h3AA;

    // 1: two-sample frame
    do_reset();
    check("rst_data_out", {31'd0, data_out}, 32'd0);
    check("rst_ws", {31'd0, WS}, 32'd0);
    check("rst_slot_start", {31'd0, slot_start}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    push(SA);
    push(SB);
    check("s1_level2", {29'd0, fifo_level}, 32'd2);
    expect_slot(1'b0, PA);
    expect_slot(1'b1, PB);
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    check("s1_first_start", {31'd0, slot_start}, 32'd1);
    check("s1_first_bit", {31'd0, data_out}, {31'd0, PA[0]});
    check("s1_level_after_pop", {29'd0, fifo_level}, 32'd1);
    tick();
    check("s1_pulse_one_cycle", {31'd0, slot_start}, 32'd0);
    repeat (15) tick();
    check("s1_right_start", {30'd0, slot_start, WS}, 32'd3);
    check("s1_level_empty", {29'd0, fifo_level}, 32'd0);
    repeat (20) tick();
    check("s1_idle_out", {30'd0, WS, data_out}, 32'd0);
    check("s1_underrun_clear", {31'd0, underrun}, 32'd0);
    check("s1_sb_empty", exp_q.size(), 32'd0);

    // 2: FIFO full / s_ready
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = cs[i];
      tick();
      if (i == 3) begin
        check("s2_ready_low_at_4", {31'd0, s_ready}, 32'd0);
        check("s2_level_4", {29'd0, fifo_level}, 32'd4);
      end
    end
    check("s2_fifth_rejected", {29'd0, fifo_level}, 32'd4);
    expect_slot(1'b0, PONES);
    expect_slot(1'b1, PPAL);
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    s_valid = 1'b0;
    check("s2_pop_no_reopen", {29'd0, fifo_level}, 32'd3);
    check("s2_ready_after_pop", {31'd0, s_ready}, 32'd1);
    repeat (40) tick();
    check("s2_level_after_frame", {29'd0, fifo_level}, 32'd2);
    check("s2_sb_empty", exp_q.size(), 32'd0);

    // 3: underrun
    do_reset();
    expect_slot(1'b0, 16'h0000);
    expect_slot(1'b1, 16'h0000);
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    check("s3_underrun_set", {31'd0, underrun}, 32'd1);
    repeat (4) tick();
    check("s3_underrun_sticky", {31'd0, underrun}, 32'd1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("s3_underrun_cleared", {31'd0, underrun}, 32'd0);
    repeat (10) tick();
    check("s3_underrun_stays_clear", {31'd0, underrun}, 32'd0);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("s3_set_beats_clear", {30'd0, underrun, WS}, 32'd3);
    repeat (30) tick();
    check("s3_idle_ws", {31'd0, WS}, 32'd0);
    check("s3_sb_empty", exp_q.size(), 32'd0);

    // 4: tx_en dropped mid left slot
    do_reset();
    push(SA);
    push(SB);
    push(11'h2C3);
    expect_slot(1'b0, PA);
    expect_slot(1'b1, PB);
    tx_en = 1'b1;
    tick();
    repeat (3) tick();
    tx_en = 1'b0;
    repeat (28) tick();
    check("s4_right_last_cycle", {31'd0, WS}, 32'd1);
    tick();
    check("s4_idle_at_boundary", {29'd0, WS, data_out, slot_start}, 32'd0);
    repeat (20) tick();
    check("s4_idle_later", {29'd0, WS, data_out, slot_start}, 32'd0);
    check("s4_level_two_pops", {29'd0, fifo_level}, 32'd1);
    check("s4_sb_empty", exp_q.size(), 32'd0);

    // 5: async reset mid slot
    do_reset();
    push(SONES);
    push(SONES);
    push(SONES);
    expect_slot(1'b0, PONES);
    tx_en = 1'b1;
    tick();
    repeat (5) tick();
    check("s5_pre_reset_bit", {31'd0, data_out}, 32'd1);
    check("s5_pre_reset_level", {29'd0, fifo_level}, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("s5_async_data_out", {31'd0, data_out}, 32'd0);
    check("s5_async_ws_ss_und", {29'd0, WS, slot_start, underrun}, 32'd0);
    check("s5_async_level", {29'd0, fifo_level}, 32'd0);
    check("s5_async_s_ready", {31'd0, s_ready}, 32'd1);
    tx_en = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    check("s5_idle_after", {29'd0, WS, data_out, slot_start}, 32'd0);
    check("s5_sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
